// File: rtl/branch_resolve_ctrl.sv
// rtl/branch_resolve_ctrl.sv - correlated branch predictor resolve/update sequencer
module branch_resolve_ctrl #(
  parameter int DEPTH       = 4,
  parameter int PC_W        = 32,
  parameter int RECOVER_CYC = 2,
  parameter int CNT_W       = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     d_valid,
  input  logic [PC_W-1:0]          d_pc,
  input  logic                     d_pred_taken,
  input  logic                     x_valid,
  input  logic [PC_W-1:0]          x_pc,
  input  logic                     x_taken,
  input  logic                     ext_flush,
  output logic                     stall_d,
  output logic                     upd_en,
  output logic [PC_W-1:0]          upd_pc,
  output logic                     upd_pred_taken,
  output logic                     upd_wrong,
  output logic                     mispredict_flush,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     err,
  output logic [CNT_W-1:0]         stat_branches,
  output logic [CNT_W-1:0]         stat_mispredicts
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = $clog2(RECOVER_CYC + 1);

  typedef enum logic [0:0] {ST_RUN, ST_RECOVER} state_t;

  state_t            state_q, state_d;
  logic [RW-1:0]     rcnt_q, rcnt_d;
  logic [AW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PC_W-1:0]   mem_pc_q [DEPTH];
  logic              mem_pred_q [DEPTH];
  logic              upd_en_q, upd_en_d;
  logic [PC_W-1:0]   upd_pc_q, upd_pc_d;
  logic              upd_pred_q, upd_pred_d;
  logic              upd_wrong_q, upd_wrong_d;
  logic              flush_q, flush_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  nbr_q, nbr_d, nmp_q, nmp_d;

  logic              in_run, pop, wrong, wr_en;
  logic [PC_W-1:0]   head_pc;
  logic              head_pred;

  assign head_pc   = mem_pc_q[head_q];
  assign head_pred = mem_pred_q[head_q];

  // Queue bookkeeping, resolution, recovery sequencing and statistics
  always_comb begin
    state_d     = state_q;
    rcnt_d      = rcnt_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    upd_en_d    = 1'b0;
    flush_d     = 1'b0;
    upd_pc_d    = upd_pc_q;
    upd_pred_d  = upd_pred_q;
    upd_wrong_d = upd_wrong_q;
    err_d       = err_q;
    wr_en       = 1'b0;
    pop         = 1'b0;
    wrong       = 1'b0;
    in_run      = (state_q == ST_RUN);

    // Statistics follow the registered strobe; saturate instead of wrapping.
    nbr_d = (upd_en_q && (nbr_q != '1)) ? nbr_q + CNT_W'(1) : nbr_q;
    nmp_d = (upd_en_q && upd_wrong_q && (nmp_q != '1)) ? nmp_q + CNT_W'(1) : nmp_q;

    if (in_run && x_valid) begin
      if (count_q == '0) begin
        err_d = 1'b1;
      end else begin
        // A PC mismatch is flagged but the head entry is still retired.
        if (head_pc != x_pc) err_d = 1'b1;
        pop         = 1'b1;
        wrong       = (head_pred != x_taken);
        upd_en_d    = 1'b1;
        upd_pc_d    = head_pc;
        upd_pred_d  = head_pred;
        upd_wrong_d = wrong;
        flush_d     = wrong;
        head_d      = head_q + AW'(1);
      end
    end

    // Wrong-path pushes (mispredict or external flush) are silently discarded.
    if (in_run && d_valid && !ext_flush && !wrong) begin
      if ((count_q != CW'(DEPTH)) || pop) begin
        wr_en  = 1'b1;
        tail_d = tail_q + AW'(1);
      end else begin
        err_d = 1'b1;
      end
    end

    count_d = count_q + CW'(wr_en) - CW'(pop);

    case (state_q)
      ST_RUN: begin
        if (wrong) begin
          state_d = ST_RECOVER;
          rcnt_d  = RW'(RECOVER_CYC - 1);
        end
      end
      ST_RECOVER: begin
        if (rcnt_q == '0) state_d = ST_RUN;
        else              rcnt_d  = rcnt_q - RW'(1);
      end
      default: state_d = ST_RUN;
    endcase

    if (wrong || ext_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end

    if (ext_flush) begin
      state_d = ST_RUN;
      rcnt_d  = '0;
    end
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_RUN;
      rcnt_q      <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      upd_en_q    <= 1'b0;
      upd_pc_q    <= '0;
      upd_pred_q  <= 1'b0;
      upd_wrong_q <= 1'b0;
      flush_q     <= 1'b0;
      err_q       <= 1'b0;
      nbr_q       <= '0;
      nmp_q       <= '0;
    end else begin
      state_q     <= state_d;
      rcnt_q      <= rcnt_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      upd_en_q    <= upd_en_d;
      upd_pc_q    <= upd_pc_d;
      upd_pred_q  <= upd_pred_d;
      upd_wrong_q <= upd_wrong_d;
      flush_q     <= flush_d;
      err_q       <= err_d;
      nbr_q       <= nbr_d;
      nmp_q       <= nmp_d;
    end
  end

  // Queue payload storage; validity is tracked by the pointers alone
  always_ff @(posedge clock) begin
    if (wr_en && !reset) begin
      mem_pc_q[tail_q]   <= d_pc;
      mem_pred_q[tail_q] <= d_pred_taken;
    end
  end

  assign stall_d          = (state_q == ST_RUN) && (count_q == CW'(DEPTH));
  assign upd_en           = upd_en_q;
  assign upd_pc           = upd_pc_q;
  assign upd_pred_taken   = upd_pred_q;
  assign upd_wrong        = upd_wrong_q;
  assign mispredict_flush = flush_q;
  assign q_count          = count_q;
  assign err              = err_q;
  assign stat_branches    = nbr_q;
  assign stat_mispredicts = nmp_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb/tb_branch_resolve_ctrl.sv - self-checking bench for branch_resolve_ctrl
module tb_branch_resolve_ctrl;

  localparam int DEPTH = 4;
  localparam int RCYC  = 2;

  logic        clock = 1'b0;
  logic        reset, d_valid, d_pred_taken, x_valid, x_taken, ext_flush;
  logic [31:0] d_pc, x_pc;

  logic        a_stall, a_upd_en, a_upd_pred, a_upd_wrong, a_flush, a_err;
  logic [31:0] a_upd_pc;
  logic [2:0]  a_qc;
  logic [15:0] a_nbr, a_nmp;

  logic        b_stall, b_upd_en, b_upd_pred, b_upd_wrong, b_flush, b_err;
  logic [31:0] b_upd_pc;
  logic [2:0]  b_qc;
  logic [1:0]  b_nbr, b_nmp;

  always #5 clock = ~clock;

  branch_resolve_ctrl #(.DEPTH(DEPTH), .PC_W(32), .RECOVER_CYC(RCYC), .CNT_W(16)) u_dut (
    .clock(clock), .reset(reset), .d_valid(d_valid), .d_pc(d_pc), .d_pred_taken(d_pred_taken),
    .x_valid(x_valid), .x_pc(x_pc), .x_taken(x_taken), .ext_flush(ext_flush),
    .stall_d(a_stall), .upd_en(a_upd_en), .upd_pc(a_upd_pc), .upd_pred_taken(a_upd_pred),
    .upd_wrong(a_upd_wrong), .mispredict_flush(a_flush), .q_count(a_qc), .err(a_err),
    .stat_branches(a_nbr), .stat_mispredicts(a_nmp));

  branch_resolve_ctrl #(.DEPTH(DEPTH), .PC_W(32), .RECOVER_CYC(RCYC), .CNT_W(2)) u_sat (
    .clock(clock), .reset(reset), .d_valid(d_valid), .d_pc(d_pc), .d_pred_taken(d_pred_taken),
    .x_valid(x_valid), .x_pc(x_pc), .x_taken(x_taken), .ext_flush(ext_flush),
    .stall_d(b_stall), .upd_en(b_upd_en), .upd_pc(b_upd_pc), .upd_pred_taken(b_upd_pred),
    .upd_wrong(b_upd_wrong), .mispredict_flush(b_flush), .q_count(b_qc), .err(b_err),
    .stat_branches(b_nbr), .stat_mispredicts(b_nmp));

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: in-flight branches as a queue, recovery as cycles remaining.
  typedef struct { logic [31:0] pc; logic pred; } ent_t;
  ent_t        mq[$];
  logic        m_ok = 1'b0;
  logic        m_upd_en, m_upd_pred, m_upd_wrong, m_flush, m_err;
  logic [31:0] m_upd_pc;
  int          m_nbr, m_nmp, m_rec;

  function automatic int satv(input int n, input int w);
    int top;
    top = (1 << w) - 1;
    return (n > top) ? top : n;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      mq.delete();
      m_ok = 1'b1; m_upd_en = 0; m_upd_pred = 0; m_upd_wrong = 0; m_flush = 0; m_err = 0;
      m_upd_pc = 0; m_nbr = 0; m_nmp = 0; m_rec = 0;
    end else if (m_ok) begin
      logic run, wr;
      ent_t h;
      if (m_upd_en) begin
        m_nbr++;
        if (m_upd_wrong) m_nmp++;
      end
      run = (m_rec == 0);
      wr = 1'b0;
      m_upd_en = 1'b0;
      m_flush = 1'b0;
      if (m_rec > 0) m_rec--;
      if (run && x_valid) begin
        if (mq.size() == 0) m_err = 1'b1;
        else begin
          h = mq.pop_front();
          if (h.pc != x_pc) m_err = 1'b1;
          m_upd_en = 1'b1; m_upd_pc = h.pc; m_upd_pred = h.pred;
          wr = (h.pred != x_taken);
          m_upd_wrong = wr; m_flush = wr;
        end
      end
      if (run && d_valid && !ext_flush && !wr) begin
        if (mq.size() < DEPTH) mq.push_back('{pc: d_pc, pred: d_pred_taken});
        else m_err = 1'b1;
      end
      if (wr) begin mq.delete(); m_rec = RCYC; end
      if (ext_flush) begin mq.delete(); m_rec = 0; end
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge clock) begin
    if (m_ok) begin
      chk("stall_d", {31'd0, a_stall}, {31'd0, (m_rec == 0) && (mq.size() == DEPTH)});
      chk("upd_en", {31'd0, a_upd_en}, {31'd0, m_upd_en});
      chk("upd_pc", a_upd_pc, m_upd_pc);
      chk("upd_pred_taken", {31'd0, a_upd_pred}, {31'd0, m_upd_pred});
      chk("upd_wrong", {31'd0, a_upd_wrong}, {31'd0, m_upd_wrong});
      chk("mispredict_flush", {31'd0, a_flush}, {31'd0, m_flush});
      chk("q_count", {29'd0, a_qc}, 32'(mq.size()));
      chk("err", {31'd0, a_err}, {31'd0, m_err});
      chk("stat_branches", {16'd0, a_nbr}, 32'(satv(m_nbr, 16)));
      chk("stat_mispredicts", {16'd0, a_nmp}, 32'(satv(m_nmp, 16)));
      chk("sat_upd_en", {31'd0, b_upd_en}, {31'd0, m_upd_en});
      chk("sat_q_count", {29'd0, b_qc}, 32'(mq.size()));
      chk("sat_stat_branches", {30'd0, b_nbr}, 32'(satv(m_nbr, 2)));
      chk("sat_stat_mispredicts", {30'd0, b_nmp}, 32'(satv(m_nmp, 2)));
    end
  end

  task automatic cyc(input logic rs, input logic dv, input logic [31:0] dpc, input logic dp,
                     input logic xv, input logic [31:0] xpc, input logic xt, input logic ef);
    reset = rs; d_valid = dv; d_pc = dpc; d_pred_taken = dp;
    x_valid = xv; x_pc = xpc; x_taken = xt; ext_flush = ef;
    @(negedge clock);
  endtask

  task automatic rst();        cyc(1, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic idle();       cyc(0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic push(input logic [31:0] pc, input logic p); cyc(0, 1, pc, p, 0, 0, 0, 0); endtask
  task automatic pop(input logic [31:0] pc, input logic t);  cyc(0, 0, 0, 0, 1, pc, t, 0); endtask

  initial begin
    rst(); rst();
    chk("lit_reset_q_count", {29'd0, a_qc}, 32'd0);
    chk("lit_reset_err", {31'd0, a_err}, 32'd0);
    chk("lit_reset_upd_en", {31'd0, a_upd_en}, 32'd0);

    push(32'h10, 1); push(32'h20, 0);
    pop(32'h10, 1);
    chk("lit_res1_upd_pc", a_upd_pc, 32'h10);
    chk("lit_res1_wrong", {31'd0, a_upd_wrong}, 32'd0);
    pop(32'h20, 0);
    chk("lit_res2_en", {31'd0, a_upd_en}, 32'd1);
    idle();
    chk("lit_two_branches", {16'd0, a_nbr}, 32'd2);
    chk("lit_drained", {29'd0, a_qc}, 32'd0);

    push(32'h40, 1); push(32'h44, 1);
    cyc(0, 1, 32'h4C, 1, 1, 32'h40, 0, 0);
    chk("lit_mp_wrong", {31'd0, a_upd_wrong}, 32'd1);
    chk("lit_mp_flush", {31'd0, a_flush}, 32'd1);
    chk("lit_mp_cleared", {29'd0, a_qc}, 32'd0);
    chk("lit_mp_no_err", {31'd0, a_err}, 32'd0);
    for (int i = 0; i < RCYC; i++) begin
      cyc(0, 1, 32'h48, 1, 1, 32'h44, 1, 0);
      chk("lit_rec_flush_pulse", {31'd0, a_flush}, 32'd0);
      chk("lit_rec_ignored", {29'd0, a_qc}, 32'd0);
      chk("lit_rec_hold_pc", a_upd_pc, 32'h40);
    end
    push(32'h48, 1);
    chk("lit_back_to_run", {29'd0, a_qc}, 32'd1);
    pop(32'h48, 1);

    for (int i = 0; i < 4; i++) push(32'h30 + 32'(i), 1);
    chk("lit_full_stall", {31'd0, a_stall}, 32'd1);
    chk("lit_full_count", {29'd0, a_qc}, 32'd4);
    push(32'h34, 1);
    chk("lit_overflow_err", {31'd0, a_err}, 32'd1);
    cyc(0, 1, 32'h35, 1, 1, 32'h30, 1, 0);
    chk("lit_full_pushpop", {29'd0, a_qc}, 32'd4);
    pop(32'h31, 1); pop(32'h32, 1); pop(32'h33, 1); pop(32'h35, 1);
    chk("lit_full_drained", {29'd0, a_qc}, 32'd0);

    rst();
    pop(32'h12, 0);
    chk("lit_empty_err", {31'd0, a_err}, 32'd1);
    chk("lit_empty_no_upd", {31'd0, a_upd_en}, 32'd0);

    rst();
    push(32'h50, 0);
    pop(32'h99, 0);
    chk("lit_pcmis_err", {31'd0, a_err}, 32'd1);
    chk("lit_pcmis_upd_pc", a_upd_pc, 32'h50);

    rst();
    push(32'h70, 1); push(32'h74, 0); push(32'h78, 1);
    chk("lit_three_queued", {29'd0, a_qc}, 32'd3);
    cyc(0, 1, 32'h7C, 1, 0, 0, 0, 1);
    chk("lit_extflush_clear", {29'd0, a_qc}, 32'd0);
    idle();
    chk("lit_extflush_push_dropped", {29'd0, a_qc}, 32'd0);

    rst();
    for (int i = 0; i < 5; i++) begin
      push(32'h60, 1); pop(32'h60, 0); idle(); idle();
    end
    idle();
    chk("lit_sat_mispredicts", {30'd0, b_nmp}, 32'd3);
    chk("lit_sat_branches", {30'd0, b_nbr}, 32'd3);
    chk("lit_wide_mispredicts", {16'd0, a_nmp}, 32'd5);

    push(32'h80, 0);
    pop(32'h80, 1);
    chk("lit_pre_reset_flush", {31'd0, a_flush}, 32'd1);
    rst();
    chk("lit_midrec_upd_en", {31'd0, a_upd_en}, 32'd0);
    chk("lit_midrec_upd_pc", a_upd_pc, 32'd0);
    chk("lit_midrec_wrong", {31'd0, a_upd_wrong}, 32'd0);
    chk("lit_midrec_flush", {31'd0, a_flush}, 32'd0);
    chk("lit_midrec_stats", {16'd0, a_nbr}, 32'd0);
    push(32'h84, 1);
    chk("lit_midrec_run", {29'd0, a_qc}, 32'd1);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
